mips_multicycle_core: RTL and testbench
=======================================

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- IMEM_AW, 10, instruction byte-address bits driven.
- DMEM_AW, 11, data byte-address bits driven.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  IMEM_AW  fetch byte address.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data request.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  DMEM_AW  data byte address.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  data transfer complete.
- dmem_rdata  in  32  load data.
- pc  out  32  current PC.
- state  out  3  FSM state encoding.
- halted  out  1  core stopped.
- retire  out  1  one-cycle pulse per completed instruction.

Function
REQ-003 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-004 FETCH SHALL hold imem_req=1 and imem_addr=pc[IMEM_AW-1:0] until imem_ack=1; on ack it SHALL latch imem_rdata into IR, set pc=pc+4 (mod 2^32) and go to DECODE.
REQ-005 DECODE SHALL read rs and rt from a 32x32 register file; reads of $0 SHALL return 0.
REQ-006 Supported opcodes:
- R-type 000000, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
- addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
REQ-007 On j, DECODE SHALL set pc={pc[31:28],IR[25:0],2'b00}, pulse retire and return to FETCH (2 cycles total with zero-wait fetch).
REQ-008 An unsupported opcode, or an unsupported funct under R-type, SHALL go DECODE->HALT with no register or memory side effects.
REQ-009 EXEC SHALL compute a 32-bit ALU result:
- add/sub/addi wrap mod 2^32, with no overflow trap.
- slt is signed and yields 1 or 0.
- Immediates are sign-extended from IR[15:0].
REQ-010 For beq, EXEC SHALL set pc=pc+(sext(imm)<<2) when rs==rt, pulse retire and go to FETCH (3 cycles total).
REQ-011 For lw/sw, EXEC SHALL compute addr=rs+sext(imm); if addr[1:0]!=0 the FSM SHALL go to HALT with no memory request, otherwise to MEM.
REQ-012 MEM SHALL hold dmem_req=1, dmem_addr=addr[DMEM_AW-1:0], dmem_we (1 for sw) and dmem_wdata=rt value stable until dmem_ack=1.
- sw: on ack, pulse retire and go to FETCH (4 cycles).
- lw: on ack, latch dmem_rdata and go to WB.
REQ-013 WB SHALL write the result to the destination register, pulse retire and go to FETCH:
- R-type writes ALU result to rd (4 cycles).
- addi writes ALU result to rt (4 cycles).
- lw writes loaded data to rt (5 cycles).
- Writes to $0 SHALL be discarded.
REQ-014 imem_req and dmem_req SHALL never be asserted in the same cycle; an ack arriving while its request is low SHALL be ignored.
REQ-015 HALT SHALL set halted=1, hold all requests low and stay in HALT until rst; pc SHALL hold the address of the faulting instruction + 4.
REQ-016 retire SHALL be high for exactly one cycle per completed instruction and never in HALT.

Reset
REQ-017 While rst=1 at a clock edge, the block SHALL set:
- pc=RESET_PC, state=FETCH.
- All 32 registers to 0.
- IR to 0.
- halted=0, retire=0.
REQ-018 Reset during FETCH or MEM SHALL deassert the pending request on the next cycle; no register write or retire SHALL result from the abandoned instruction.
REQ-019 imem_req SHALL assert in the first cycle after rst deasserts.

Verification
REQ-020 Zero-wait memories, program "addi $8,$0,5; addi $9,$0,7; add $10,$8,$9" -> $10=12, retire pulses at cycles 4, 8, 12.
REQ-021 "addi $8,$0,-1; slt $9,$8,$0" -> $9=1 (signed), and "sltu-style" compare SHALL NOT be applied.
REQ-022 "sw $9,8($0)" with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with addr=8, we=1 and wdata constant; then "lw $11,8($0)" -> $11 equals stored value, 5+3 cycles.
REQ-023 "beq $0,$0,-1" at pc=0x10 -> pc returns to 0x10 every 3 cycles; "j 0x40" -> pc=0x100 after 2 cycles.
REQ-024 Opcode 0x3F at pc=0x20 -> HALT, halted=1, pc=0x24, no further requests; lw from address 0x6 -> HALT with dmem_req never asserted.
REQ-025 rst asserted while dmem_req is high and ack pending -> next cycle state=FETCH, pc=RESET_PC, dmem_req=0; a late dmem_ack is ignored.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multicycle MIPS subset core
// One instruction walks FETCH/DECODE/EXEC/MEM/WB; illegal ops and misaligned accesses park in HALT.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10,
  parameter int          DMEM_AW  = 11
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic [31:0]        pc,
  output logic [2:0]         state,
  output logic               halted,
  output logic               retire
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_q;
  logic [31:0] mdr_q;
  logic [31:0] regs_q [32];

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sext;
  logic        unused_shamt;

  assign opcode       = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign imm_sext     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign unused_shamt = ^ir_q[10:6];

  logic is_rtype;
  logic is_mem;
  logic op_valid;

  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    op_valid = 1'b0;
    case (opcode)
      OP_RTYPE: op_valid = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  // addi/lw/sw share the add path with the sign-extended immediate as operand b
  logic [31:0] alu_b;
  logic [31:0] alu_res;

  always_comb begin
    alu_b   = is_rtype ? b_q : imm_sext;
    alu_res = a_q + alu_b;
    if (is_rtype) begin
      case (funct)
        FN_SUB:  alu_res = a_q - alu_b;
        FN_AND:  alu_res = a_q & alu_b;
        FN_OR:   alu_res = a_q | alu_b;
        FN_SLT:  alu_res = {31'd0, ($signed(a_q) < $signed(alu_b))};
        default: alu_res = a_q + alu_b;
      endcase
    end
  end

  logic [31:0] br_target;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  assign br_target = pc_q + {imm_sext[29:0], 2'b00};
  assign wb_dest   = is_rtype ? rd : rt;
  assign wb_data   = (opcode == OP_LW) ? mdr_q : alu_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            pc_q    <= pc_q + 32'd4;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q <= (rs == 5'd0) ? 32'd0 : regs_q[rs];
          b_q <= (rt == 5'd0) ? 32'd0 : regs_q[rt];
          if (!op_valid) begin
            state_q <= S_HALT;
          end else if (opcode == OP_J) begin
            pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
            state_q <= S_FETCH;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (opcode == OP_BEQ) begin
            if (a_q == b_q) begin
              pc_q <= br_target;
            end
            state_q <= S_FETCH;
          end else if (is_mem) begin
            state_q <= (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            mdr_q   <= dmem_rdata;
            state_q <= (opcode == OP_SW) ? S_FETCH : S_WB;
          end
        end
        S_WB: begin
          if (wb_dest != 5'd0) begin
            regs_q[wb_dest] <= wb_data;
          end
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  // requests drop immediately under reset so an abandoned access is never acknowledged
  assign imem_req   = (state_q == S_FETCH) && !rst;
  assign imem_addr  = pc_q[IMEM_AW-1:0];
  assign dmem_req   = (state_q == S_MEM) && !rst;
  assign dmem_we    = (state_q == S_MEM) && (opcode == OP_SW);
  assign dmem_addr  = alu_q[DMEM_AW-1:0];
  assign dmem_wdata = b_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign halted     = (state_q == S_HALT);

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_DECODE: retire = op_valid && (opcode == OP_J);
      S_EXEC:   retire = (opcode == OP_BEQ);
      S_MEM:    retire = (opcode == OP_SW) && dmem_ack;
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
    if (rst) begin
      retire = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - directed-vector bench for mips_multicycle_core
// Zero/variable-wait memory models; register contents observed through stores.
module tb_mips_multicycle_core;

  localparam logic [31:0] SPIN = 32'h1000_FFFF;
  localparam logic [5:0]  OP_ADDI = 6'h08;
  localparam logic [5:0]  OP_LW   = 6'h23;
  localparam logic [5:0]  OP_SW   = 6'h2B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [10:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        halted;
  logic        retire;

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .state(state), .halted(halted), .retire(retire)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem [512];
  int          dly = 0;
  int          dcnt = 0;
  logic        force_ack = 1'b0;
  logic        clr = 1'b0;

  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_ack   = (dmem_req && (dcnt == dly)) || force_ack;
  assign dmem_rdata = dmem[dmem_addr[10:2]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 512; i++) dmem[i] <= 32'hDEAD_BEEF;
    end else if (dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr[10:2]] <= dmem_wdata;
    end
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end

  int          cyc = 0;
  int          ret_q [$];
  int          runs_q [$];
  int          run = 0;
  int          unst = 0;
  int          dreq_total = 0;
  int          overlap = 0;
  int          halt_req = 0;
  logic [10:0] f_addr, c_addr;
  logic [31:0] f_wd, c_wd;
  logic        f_we, c_we;

  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; ret_q.delete(); runs_q.delete(); run = 0; unst = 0;
      dreq_total = 0; overlap = 0; halt_req = 0;
    end else begin
      cyc++;
      if (retire) ret_q.push_back(cyc);
      if (imem_req && dmem_req) overlap++;
      if (halted && (imem_req || dmem_req)) halt_req++;
      if (dmem_req) begin
        dreq_total++;
        if (run == 0) begin
          c_addr = dmem_addr; c_wd = dmem_wdata; c_we = dmem_we;
          if (runs_q.size() == 0) begin
            f_addr = dmem_addr; f_wd = dmem_wdata; f_we = dmem_we;
          end
        end else if (c_addr != dmem_addr || c_wd != dmem_wdata || c_we != dmem_we) begin
          unst++;
        end
        run++;
      end else if (run > 0) begin
        runs_q.push_back(run);
        run = 0;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i_ty(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_ty(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] j_ty(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic begin_test(input int d);
    rst = 1'b1;
    force_ack = 1'b0;
    dly = d;
    @(posedge clk);
    #2;
    for (int i = 0; i < 256; i++) imem[i] = SPIN;
  endtask

  task automatic go();
    clr = 1'b1;
    @(posedge clk);
    #2;
    clr = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset values
    begin_test(0);
    @(negedge clk);
    #1;
    check_eq("rst_state", state, 0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_retire", retire, 0);
    check_eq("rst_dmem_req", dmem_req, 0);

    // addi/addi/add, result stored
    imem[0] = i_ty(OP_ADDI, 0, 8, 16'd5);
    imem[1] = i_ty(OP_ADDI, 0, 9, 16'd7);
    imem[2] = r_ty(8, 9, 10, 6'h20);
    imem[3] = i_ty(OP_SW, 0, 10, 16'd0);
    go();
    run_to(1);
    check_eq("first_imem_req", imem_req, 1);
    check_eq("first_imem_addr", imem_addr, 0);
    run_to(25);
    check_eq("add_ret0", ret_q[0], 4);
    check_eq("add_ret1", ret_q[1], 8);
    check_eq("add_ret2", ret_q[2], 12);
    check_eq("add_sw_ret", ret_q[3], 16);
    check_eq("add_r10", dmem[0], 12);
    check_eq("add_overlap", overlap, 0);

    // signed slt, sub, and, or, write to $0
    begin_test(0);
    imem[0]  = i_ty(OP_ADDI, 0, 8, 16'hFFFF);
    imem[1]  = r_ty(8, 0, 9, 6'h2A);
    imem[2]  = r_ty(0, 8, 12, 6'h2A);
    imem[3]  = r_ty(0, 8, 13, 6'h22);
    imem[4]  = r_ty(8, 9, 14, 6'h24);
    imem[5]  = r_ty(8, 0, 15, 6'h25);
    imem[6]  = i_ty(OP_ADDI, 0, 0, 16'd5);
    imem[7]  = i_ty(OP_SW, 0, 9, 16'd0);
    imem[8]  = i_ty(OP_SW, 0, 12, 16'd4);
    imem[9]  = i_ty(OP_SW, 0, 13, 16'd8);
    imem[10] = i_ty(OP_SW, 0, 14, 16'd12);
    imem[11] = i_ty(OP_SW, 0, 15, 16'd16);
    imem[12] = i_ty(OP_SW, 0, 0, 16'd20);
    go();
    run_to(60);
    check_eq("slt_neg_lt_0", dmem[0], 1);
    check_eq("slt_0_lt_neg", dmem[1], 0);
    check_eq("sub_0_m1", dmem[2], 1);
    check_eq("and_m1_1", dmem[3], 1);
    check_eq("or_m1_0", dmem[4], 32'hFFFF_FFFF);
    check_eq("r0_stays_0", dmem[5], 0);

    // sw/lw with ack delayed 3 cycles
    begin_test(3);
    imem[0] = i_ty(OP_ADDI, 0, 9, 16'h1234);
    imem[1] = i_ty(OP_SW, 0, 9, 16'd8);
    imem[2] = i_ty(OP_LW, 0, 11, 16'd8);
    imem[3] = i_ty(OP_SW, 0, 11, 16'd12);
    go();
    run_to(30);
    check_eq("sw_req_len", runs_q[0], 4);
    check_eq("sw_addr", f_addr, 8);
    check_eq("sw_we", f_we, 1);
    check_eq("sw_wdata", f_wd, 32'h1234);
    check_eq("mem_stable", unst, 0);
    check_eq("sw_cycles", ret_q[1] - ret_q[0], 7);
    check_eq("lw_cycles", ret_q[2] - ret_q[1], 8);
    check_eq("lw_req_len", runs_q[1], 4);
    check_eq("lw_roundtrip", dmem[3], 32'h1234);
    check_eq("mem_overlap", overlap, 0);

    // j 0x40, j 0x4, beq $0,$0,-1 at 0x10
    begin_test(0);
    imem[0]  = j_ty(26'h40);
    imem[64] = j_ty(26'h4);
    go();
    run_to(3);
    check_eq("j_pc", pc, 32'h100);
    run_to(5);
    check_eq("j2_pc", pc, 32'h10);
    check_eq("j2_imem_addr", imem_addr, 10'h10);
    run_to(6);
    check_eq("beq_decode_pc", pc, 32'h14);
    run_to(8);
    check_eq("beq_taken_pc", pc, 32'h10);
    run_to(14);
    check_eq("j_ret", ret_q[0], 2);
    check_eq("j2_ret", ret_q[1], 4);
    check_eq("beq_ret0", ret_q[2], 7);
    check_eq("beq_ret1", ret_q[3], 10);
    check_eq("beq_ret2", ret_q[4], 13);

    // illegal opcode 0x3F at 0x20
    begin_test(0);
    imem[0] = j_ty(26'h8);
    imem[8] = 32'hFC00_0000;
    go();
    run_to(15);
    check_eq("ill_halted", halted, 1);
    check_eq("ill_state", state, 5);
    check_eq("ill_pc", pc, 32'h24);
    check_eq("ill_no_req", halt_req, 0);
    check_eq("ill_retires", ret_q.size(), 1);
    check_eq("ill_retire_low", retire, 0);

    // unsupported funct under R-type
    begin_test(0);
    imem[0] = r_ty(0, 0, 8, 6'h21);
    go();
    run_to(10);
    check_eq("fn_halted", halted, 1);
    check_eq("fn_pc", pc, 32'h4);
    check_eq("fn_retires", ret_q.size(), 0);

    // misaligned lw
    begin_test(0);
    imem[0] = i_ty(OP_LW, 0, 11, 16'd6);
    go();
    run_to(10);
    check_eq("mis_halted", halted, 1);
    check_eq("mis_pc", pc, 32'h4);
    check_eq("mis_no_dreq", dreq_total, 0);

    // reset while a store waits for its ack
    begin_test(100);
    imem[0] = i_ty(OP_ADDI, 0, 9, 16'h0055);
    imem[1] = i_ty(OP_SW, 0, 9, 16'd0);
    go();
    run_to(9);
    check_eq("pre_rst_dreq", dmem_req, 1);
    check_eq("pre_rst_state", state, 3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_eq("abort_state", state, 0);
    check_eq("abort_pc", pc, 32'h0);
    check_eq("abort_dreq", dmem_req, 0);
    check_eq("abort_no_store", dmem[0], 32'hDEAD_BEEF);
    dly = 3;
    @(posedge clk);
    #2;
    rst = 1'b0;
    force_ack = 1'b1;
    run_to(2);
    force_ack = 1'b0;
    check_eq("late_ack_state", state, 1);
    run_to(5);
    check_eq("late_ack_no_store", dmem[0], 32'hDEAD_BEEF);
    check_eq("restart_ret0", ret_q[0], 4);
    run_to(20);
    check_eq("restart_store", dmem[0], 32'h55);
    check_eq("restart_ret1", ret_q[1], 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
